// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the single-ported memory controller between instruction fetch and data accesses.
// Data accesses have priority; a starvation bound guarantees fetch progress, and flushed fetches are discarded.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t            state, state_nxt;
  logic              kill, kill_nxt;
  logic [SW-1:0]     starve_cnt, starve_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              if_elig, grant_d, grant_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      kill       <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      kill       <= kill_nxt;
      starve_cnt <= starve_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    kill_nxt      = kill;
    starve_nxt    = starve_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_elig       = if_req & ~if_flush;
    grant_d       = 1'b0;
    grant_if      = 1'b0;

    case (state)
      IDLE: begin
        kill_nxt = 1'b0;
        // Data wins a tie unless fetch has already waited STARVE_MAX data grants.
        grant_d  = d_req & (~if_elig | (starve_cnt != STARVE_TOP));
        grant_if = if_elig & ~grant_d;
        if (grant_d) begin
          state_nxt     = BUSY_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          if (!if_req)
            starve_nxt = '0;
          else if (starve_cnt != STARVE_TOP)
            starve_nxt = starve_cnt + 1'b1;
        end else if (grant_if) begin
          state_nxt     = BUSY_IF;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
          starve_nxt    = '0;
        end else if (!if_req) begin
          starve_nxt = '0;
        end
      end
      BUSY_IF: begin
        if (if_flush)
          kill_nxt = 1'b1;
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          kill_nxt    = 1'b0;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A flush in the ack cycle itself must suppress the response, so the live flush joins the registered kill.
  assign if_valid = mem_ack & (state == BUSY_IF) & ~(kill | if_flush);
  assign d_valid  = mem_ack & (state == BUSY_D);
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule
